// File: rtl/cmat_mac_scheduler_if.sv
// cmat_mac_scheduler_if: operand-fetch and result-stream signals of the MAC scheduler
interface cmat_mac_scheduler_if #(parameter int DW = 18);
  logic [3:0] a_addr, b_addr, res_idx;
  logic [DW-1:0] a_r, a_i, b_r, b_i, res_r, res_i;
  logic res_valid, res_ready;
  modport master(
    output a_addr, b_addr, res_valid, res_idx, res_r, res_i,
    input a_r, a_i, b_r, b_i, res_ready
  );
  modport slave(
    input a_addr, b_addr, res_valid, res_idx, res_r, res_i,
    output a_r, a_i, b_r, b_i, res_ready
  );
endinterface

// File: rtl/cmat_mac_scheduler.sv
// cmat_mac_scheduler: 4x4 complex matrix product on one shared complex MAC, streamed out row-major
module cmat_mac_scheduler #(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE = 12,
  parameter int DATA_WIDTH = INTEGER_SIZE + FRACT_SIZE,
  parameter int ACC_WIDTH = 2*DATA_WIDTH + 4
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic abort,
  output logic busy,
  output logic done,
  cmat_mac_scheduler_if.master bus
);
  typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;
  localparam logic signed [ACC_WIDTH-1:0] HALF = {{(ACC_WIDTH-FRACT_SIZE){1'b0}}, 1'b1, {(FRACT_SIZE-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] MAXV = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;
  state_t state, state_nx;
  logic [1:0] i, j, k;
  logic signed [ACC_WIDTH-1:0] acc_r, acc_i, sum_r, sum_i, ar, ai, br, bi;
  logic accept;
  function automatic logic [DATA_WIDTH-1:0] rnd(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] t;
    t = (v + HALF) >>> FRACT_SIZE;
    return t > MAXV ? MAXV[DATA_WIDTH-1:0] : t < MINV ? MINV[DATA_WIDTH-1:0] : t[DATA_WIDTH-1:0];
  endfunction
  assign ar = ACC_WIDTH'($signed(bus.a_r));
  assign ai = ACC_WIDTH'($signed(bus.a_i));
  assign br = ACC_WIDTH'($signed(bus.b_r));
  assign bi = ACC_WIDTH'($signed(bus.b_i));
  assign sum_r = acc_r + ar * br - ai * bi;
  assign sum_i = acc_i + ar * bi + ai * br;
  assign accept = bus.res_valid & bus.res_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign bus.a_addr = state == MAC ? {i, k} : 4'd0;
  assign bus.b_addr = state == MAC ? {k, j} : 4'd0;
  always_comb begin
    state_nx = abort ? IDLE
             : state == IDLE ? (start ? MAC : IDLE)
             : state == MAC ? (k == 2'd3 ? OUT : MAC)
             : state == OUT ? (accept ? (bus.res_idx == 4'd15 ? DONE : MAC) : OUT)
             : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {i, j, k} <= '0;
      acc_r <= '0;
      acc_i <= '0;
      bus.res_valid <= 1'b0;
      bus.res_idx <= '0;
      bus.res_r <= '0;
      bus.res_i <= '0;
    end else if (abort) begin
      bus.res_valid <= 1'b0;
    end else if (state == IDLE && start) begin
      {i, j, k} <= '0;
      acc_r <= '0;
      acc_i <= '0;
    end else if (state == MAC) begin
      k <= k + 2'd1;
      acc_r <= sum_r;
      acc_i <= sum_i;
      if (k == 2'd3) begin
        bus.res_r <= rnd(sum_r);
        bus.res_i <= rnd(sum_i);
        bus.res_idx <= {i, j};
        bus.res_valid <= 1'b1;
      end
    end else if (state == OUT && accept) begin
      bus.res_valid <= 1'b0;
      {i, j} <= {i, j} + 4'd1;
      k <= '0;
      acc_r <= '0;
      acc_i <= '0;
    end
  end
endmodule

// File: tb/tb_cmat_mac_scheduler.sv
// tb_cmat_mac_scheduler: directed checks of results, timing, backpressure, abort and reset
module tb_cmat_mac_scheduler;
  logic clk_tb = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, busy, done;
  logic [17:0] ma_r[16], ma_i[16], mb_r[16], mb_i[16], exp_r[16], exp_i[16];
  int tests = 0, fails = 0, cyc = 0;
  cmat_mac_scheduler_if #(.DW(18)) bus();
  cmat_mac_scheduler dut(
    .clk(clk_tb), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .bus(bus.master)
  );
  always #5 clk_tb = ~clk_tb;
  assign bus.a_r = ma_r[bus.a_addr];
  assign bus.a_i = ma_i[bus.a_addr];
  assign bus.b_r = mb_r[bus.b_addr];
  assign bus.b_i = mb_i[bus.b_addr];
  task automatic step;
    @(posedge clk_tb);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic zero_all;
    for (int n = 0; n < 16; n++) begin
      ma_r[n] = '0; ma_i[n] = '0; mb_r[n] = '0; mb_i[n] = '0;
      exp_r[n] = '0; exp_i[n] = '0;
    end
  endtask
  task automatic load_ident;
    zero_all();
    for (int n = 0; n < 16; n++) begin
      mb_r[n] = 18'(n * 'h1000);
      exp_r[n] = 18'(n * 'h1000);
    end
    for (int n = 0; n < 4; n++) ma_r[n*5] = 18'h01000;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_idx"}, 32'(bus.res_idx), 0);
    chk({tag, "_res_r"}, 32'(bus.res_r), 0);
    chk({tag, "_res_i"}, 32'(bus.res_i), 0);
    chk({tag, "_a_addr"}, 32'(bus.a_addr), 0);
    chk({tag, "_b_addr"}, 32'(bus.b_addr), 0);
  endtask
  task automatic run(input int stall_el, input int stall, input int abort_el);
    int e0;
    start = 1'b1;
    step();
    start = 1'b0;
    e0 = cyc;
    for (int n = 0; n < 16; n++) begin
      step();
      chk("a_addr_k1", 32'(bus.a_addr), (n / 4) * 4 + 1);
      chk("b_addr_k1", 32'(bus.b_addr), 4 + n % 4);
      if (n == 2) start = 1'b1;
      step();
      start = 1'b0;
      if (n == abort_el) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(bus.res_valid), 0);
        chk("abort_done", 32'(done), 0);
        repeat (3) begin
          step();
          chk("abort_no_done", 32'(done), 0);
          chk("abort_idle", 32'(busy), 0);
        end
        return;
      end
      step();
      chk("early_valid", 32'(bus.res_valid), 0);
      step();
      chk("valid", 32'(bus.res_valid), 1);
      chk("res_idx", 32'(bus.res_idx), n);
      chk("res_r", 32'(bus.res_r), 32'(exp_r[n]));
      chk("res_i", 32'(bus.res_i), 32'(exp_i[n]));
      if (n == stall_el) begin
        bus.res_ready = 1'b0;
        repeat (stall) begin
          step();
          chk("stall_valid", 32'(bus.res_valid), 1);
          chk("stall_idx", 32'(bus.res_idx), n);
          chk("stall_res_r", 32'(bus.res_r), 32'(exp_r[n]));
          chk("stall_res_i", 32'(bus.res_i), 32'(exp_i[n]));
        end
        bus.res_ready = 1'b1;
      end
      step();
      chk("valid_drop", 32'(bus.res_valid), 0);
      if (n == 15) begin
        chk("done_pulse", 32'(done), 1);
        chk("busy_in_done", 32'(busy), 1);
        chk("accept_edge", cyc - e0, 80 + (stall_el >= 0 ? stall : 0));
        step();
        chk("done_clear", 32'(done), 0);
        chk("busy_clear", 32'(busy), 0);
      end else begin
        chk("no_early_done", 32'(done), 0);
      end
    end
  endtask
  initial begin
    zero_all();
    bus.res_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    load_ident();
    run(-1, 0, 16);
    run(5, 3, 16);
    zero_all();
    ma_r[0] = 18'h01000; ma_i[0] = 18'h02000;
    mb_r[0] = 18'h03000; mb_i[0] = 18'h04000;
    exp_r[0] = 18'h3B000; exp_i[0] = 18'h0A000;
    run(-1, 0, 16);
    zero_all();
    for (int n = 0; n < 16; n++) begin
      ma_r[n] = 18'h08000; mb_r[n] = 18'h08000; exp_r[n] = 18'h1FFFF;
    end
    run(-1, 0, 16);
    for (int n = 0; n < 16; n++) begin
      ma_r[n] = 18'h38000; exp_r[n] = 18'h20000;
    end
    run(-1, 0, 16);
    zero_all();
    ma_r[0] = 18'h00001; mb_r[0] = 18'h00800; exp_r[0] = 18'h00001;
    run(-1, 0, 16);
    load_ident();
    run(-1, 0, 7);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_same_edge", 32'(busy), 0);
    run(-1, 0, 16);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    bus.res_ready = 1'b0;
    chk("pre_rst_valid", 32'(bus.res_valid), 1);
    chk("pre_rst_idx", 32'(bus.res_idx), 2);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    step();
    chk("rst_held_busy", 32'(busy), 0);
    #3 rst = 1'b0;
    bus.res_ready = 1'b1;
    step();
    run(-1, 0, 16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
